// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
// Module   : text_console
// Purpose  : Byte-stream writer for text-mode RAM. Places coloured glyphs at a
//            hardware cursor, handles CR/LF/BS/FF, wraps lines and scrolls.
// Revision : 1.0 - initial release
// ============================================================================
module text_console #(
    parameter int WORD      = 32,
    parameter int BYTE_CNT  = 4,
    parameter int ADDRW     = 11,
    parameter int TEXT_HRES = 84,
    parameter int TEXT_VRES = 24
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                ch_valid,
    output logic                ch_ready,
    input  logic [7:0]          ch_data,
    input  logic [7:0]          ch_colr,
    output logic [BYTE_CNT-1:0] tram_we,
    output logic [ADDRW-1:0]    tram_addr,
    output logic [WORD-1:0]     tram_din,
    output logic [ADDRW-1:0]    scroll_offs,
    output logic [ADDRW-1:0]    cur_col,
    output logic [ADDRW-1:0]    cur_row,
    output logic                busy
);

    localparam int              c_AW1       = ADDRW + 1;
    localparam logic [ADDRW:0]  c_DEPTH     = c_AW1'(TEXT_HRES * TEXT_VRES);
    localparam logic [ADDRW:0]  c_HRES      = c_AW1'(TEXT_HRES);
    localparam logic [ADDRW-1:0] c_LAST_COL  = ADDRW'(TEXT_HRES - 1);
    localparam logic [ADDRW-1:0] c_LAST_ROW  = ADDRW'(TEXT_VRES - 1);
    localparam logic [ADDRW-1:0] c_LAST_ADDR = ADDRW'(TEXT_HRES * TEXT_VRES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_CLR_LINE = 2'd2,
        ST_CLR_ALL  = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_data;
    logic [7:0]          r_colr;
    logic [BYTE_CNT-1:0] r_we;
    logic [ADDRW-1:0]    r_addr;
    logic [WORD-1:0]     r_din;
    logic [ADDRW-1:0]    r_scroll;
    logic [ADDRW-1:0]    r_col;
    logic [ADDRW-1:0]    r_row;
    logic [ADDRW-1:0]    r_cnt;

    logic [ADDRW:0]      w_scroll_sum;
    logic [ADDRW-1:0]    w_scroll_next;
    logic [ADDRW-1:0]    w_cell_addr;
    logic [ADDRW-1:0]    w_line_addr;
    logic [ADDRW-1:0]    w_addr_inc;
    logic                w_newline;

    // Worst-case operands (last row base + last col + max scroll) stay below
    // 2*DEPTH, so one conditional subtract yields the modulo.
    function automatic logic [ADDRW-1:0] cell_addr(input logic [ADDRW-1:0] base,
                                                   input logic [ADDRW-1:0] row,
                                                   input logic [ADDRW-1:0] col);
        logic [ADDRW:0] w_sum;
        w_sum = {1'b0, base} + ({1'b0, row} * c_HRES) + {1'b0, col};
        if (w_sum >= c_DEPTH)
            w_sum = w_sum - c_DEPTH;
        return w_sum[ADDRW-1:0];
    endfunction

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code != 8'h7F);
    endfunction

    function automatic logic [WORD-1:0] make_cell(input logic [7:0] colr,
                                                  input logic [7:0] code);
        return WORD'({colr, 16'h0000, code});
    endfunction

    always_comb begin
        w_scroll_sum  = {1'b0, r_scroll} + c_HRES;
        if (w_scroll_sum >= c_DEPTH)
            w_scroll_sum = w_scroll_sum - c_DEPTH;
        w_scroll_next = w_scroll_sum[ADDRW-1:0];
        w_cell_addr   = cell_addr(r_scroll, r_row, r_col);
        // The freshly exposed bottom line is addressed with the new offset.
        w_line_addr   = cell_addr(w_scroll_next, c_LAST_ROW, '0);
        w_addr_inc    = (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
        w_newline     = is_printable(r_data) ? (r_col == c_LAST_COL)
                                             : (r_data == 8'h0A);
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_colr   <= '0;
            r_we     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_scroll <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ch_valid) begin
                        r_data <= ch_data;
                        r_colr <= ch_colr;
                        if (ch_data == 8'h0C) begin
                            r_state <= ST_CLR_ALL;
                            r_we    <= '1;
                            r_addr  <= '0;
                            r_din   <= make_cell(ch_colr, 8'h20);
                        end else begin
                            r_state <= ST_WRITE;
                            if (is_printable(ch_data)) begin
                                r_we   <= '1;
                                r_addr <= w_cell_addr;
                                r_din  <= make_cell(ch_colr, ch_data);
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    r_we    <= '0;
                    r_state <= ST_IDLE;
                    if (is_printable(r_data)) begin
                        r_col <= (r_col == c_LAST_COL) ? '0 : r_col + 1'b1;
                    end else begin
                        case (r_data)
                            8'h0A, 8'h0D: r_col <= '0;
                            8'h08: if (r_col != '0) r_col <= r_col - 1'b1;
                            default: ;
                        endcase
                    end
                    if (w_newline) begin
                        if (r_row != c_LAST_ROW) begin
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_scroll <= w_scroll_next;
                            r_state  <= ST_CLR_LINE;
                            r_cnt    <= '0;
                            r_we     <= '1;
                            r_addr   <= w_line_addr;
                            r_din    <= make_cell(r_colr, 8'h20);
                        end
                    end
                end

                ST_CLR_LINE: begin
                    if (r_cnt == c_LAST_COL) begin
                        r_we    <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_addr <= w_addr_inc;
                    end
                end

                ST_CLR_ALL: begin
                    if (r_addr == c_LAST_ADDR) begin
                        r_we     <= '0;
                        r_scroll <= '0;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_addr <= w_addr_inc;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ch_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign tram_we     = r_we;
    assign tram_addr   = r_addr;
    assign tram_din    = r_din;
    assign scroll_offs = r_scroll;
    assign cur_col     = r_col;
    assign cur_row     = r_row;

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_console
// Purpose  : Scoreboard bench for text_console: expected tram writes are
//            queued when a byte is sent and matched as the DUT writes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_console;

    localparam int HRES  = 84;
    localparam int VRES  = 24;
    localparam int DEPTH = HRES * VRES;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  ch_data;
    logic [7:0]  ch_colr;
    logic [3:0]  tram_we;
    logic [10:0] tram_addr;
    logic [31:0] tram_din;
    logic [10:0] scroll_offs;
    logic [10:0] cur_col;
    logic [10:0] cur_row;
    logic        busy;

    always #5 clk_sys = ~clk_sys;

    text_console dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_data    (ch_data),
        .ch_colr    (ch_colr),
        .tram_we    (tram_we),
        .tram_addr  (tram_addr),
        .tram_din   (tram_din),
        .scroll_offs(scroll_offs),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .busy       (busy)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [42:0] sb[$];
    logic [42:0] mon_exp;
    int          m_col, m_row, m_scroll, m_exp_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_cell(input int row, input int col);
        return (m_scroll + row * HRES + col) % DEPTH;
    endfunction

    function automatic logic [31:0] m_word(input logic [7:0] c, input logic [7:0] d);
        return {c, 16'h0000, d};
    endfunction

    task automatic m_newline(input logic [7:0] colr);
        if (m_row < VRES - 1) begin
            m_row++;
        end else begin
            m_scroll = (m_scroll + HRES) % DEPTH;
            for (int i = 0; i < HRES; i++)
                sb.push_back({11'(m_cell(VRES - 1, i)), m_word(colr, 8'h20)});
            m_exp_cycles = 2 + HRES;
        end
    endtask

    task automatic m_apply(input logic [7:0] d, input logic [7:0] c);
        m_exp_cycles = 2;
        if (d == 8'h0C) begin
            for (int a = 0; a < DEPTH; a++)
                sb.push_back({11'(a), m_word(c, 8'h20)});
            m_scroll = 0; m_col = 0; m_row = 0;
            m_exp_cycles = DEPTH + 1;
        end else if (d >= 8'h20 && d != 8'h7F) begin
            sb.push_back({11'(m_cell(m_row, m_col)), m_word(c, d)});
            if (m_col == HRES - 1) begin
                m_col = 0;
                m_newline(c);
            end else begin
                m_col++;
            end
        end else if (d == 8'h0A) begin
            m_col = 0;
            m_newline(c);
        end else if (d == 8'h0D) begin
            m_col = 0;
        end else if (d == 8'h08 && m_col > 0) begin
            m_col--;
        end
    endtask

    // Every tram write must match the oldest outstanding expectation.
    always @(negedge clk_sys) begin
        if (rst_sys_n && tram_we != 4'h0) begin
            check("we_val", tram_we, 4'hF);
            check("busy_in_wr", busy, 1'b1);
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("wr_addr_din", {tram_addr, tram_din}, mon_exp);
            end
        end
    end

    task automatic check_reset();
        check("rst_we", tram_we, 0);
        check("rst_addr", tram_addr, 0);
        check("rst_din", tram_din, 0);
        check("rst_scroll", scroll_offs, 0);
        check("rst_col", cur_col, 0);
        check("rst_row", cur_row, 0);
        check("rst_ready", ch_ready, 1);
        check("rst_busy", busy, 0);
    endtask

    task automatic start_byte(input logic [7:0] d, input logic [7:0] c);
        m_apply(d, c);
        @(negedge clk_sys);
        check("ready_idle", ch_ready, 1);
        ch_data  = d;
        ch_colr  = c;
        ch_valid = 1'b1;
        @(posedge clk_sys);
        #1 ch_valid = 1'b0;
    endtask

    task automatic finish_byte();
        int n;
        @(negedge clk_sys);
        n = 1;
        check("ready_drop", ch_ready, 0);
        while (!ch_ready && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        check("cycles", n, m_exp_cycles);
        check("cur_col", cur_col, m_col);
        check("cur_row", cur_row, m_row);
        check("scroll", scroll_offs, m_scroll);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] c);
        start_byte(d, c);
        finish_byte();
    endtask

    task automatic pulse_reset();
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        m_col = 0; m_row = 0; m_scroll = 0;
        sb.delete();
        @(negedge clk_sys);
        check_reset();
        rst_sys_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sys_n = 1'b0;
        ch_valid  = 1'b0;
        ch_data   = 8'h00;
        ch_colr   = 8'h00;
        m_col = 0; m_row = 0; m_scroll = 0; m_exp_cycles = 2;
        repeat (3) @(negedge clk_sys);
        check_reset();
        rst_sys_n = 1'b1;

        // Single glyph at home: addr 0, din F000_0041.
        send(8'h41, 8'hF0);

        // Full line from home wraps to row 1 without scrolling.
        pulse_reset();
        for (int i = 0; i < HRES; i++)
            send(8'h30 + 8'(i % 10), 8'h1E);

        // Walk to the bottom row, then scroll 24 times: offset 84 .. 1932 .. 0.
        for (int i = 0; i < VRES - 2; i++)
            send(8'h0A, 8'h00);
        for (int i = 0; i < VRES; i++)
            send(8'h0A, 8'(8'h10 + i));
        check("scroll_wrapped", scroll_offs, 0);

        // Glyph on the bottom row after the wrap lands at 1932.
        send(8'h42, 8'hA5);

        // Cursor controls and ignored / high codes.
        send(8'h78, 8'h21);
        send(8'h08, 8'h00);
        send(8'h08, 8'h00);
        send(8'h08, 8'h00);
        send(8'h07, 8'h00);
        send(8'h7F, 8'h00);
        send(8'h80, 8'h34);
        send(8'h0D, 8'h00);
        send(8'hFF, 8'h56);

        // Full clear.
        send(8'h0C, 8'h07);

        // Reset in the middle of a clear aborts immediately.
        start_byte(8'h0C, 8'h3C);
        repeat (100) @(negedge clk_sys);
        #1 rst_sys_n = 1'b0;
        sb.delete();
        m_col = 0; m_row = 0; m_scroll = 0;
        #1 check_reset();
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        send(8'h5A, 8'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
